// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   DEF_*        : default widths, reset PC and sequential PC step
//   fetch_entry_t: {pc, instr} pair at the default widths
//   occ_width()  : bits needed to hold an occupancy of 0..depth
package fetch_pkg;

    localparam int          DEF_XLEN     = 64;
    localparam int          DEF_ILEN     = 32;
    localparam logic [63:0] DEF_RESET_PC = 64'h0;
    localparam int          DEF_PC_STEP  = 4;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO used both as the fetch queue and as the FIFO of issued
// request addresses.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : clears contents (takes priority over push/pop)
//   push      : write push_data (ignored when full)
//   pop       : drop head entry (ignored when empty)
//   head_data : current head entry, combinational from storage
//   count     : occupancy, empty : count == 0
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic [occ_width(DEPTH)-1:0] count,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Decoupled instruction fetch stage. Owns the fetch PC, issues requests to
// an in-order variable-latency instruction memory, buffers returned words
// with their PCs and hands them to decode over valid/ready. A redirect
// flushes the queue and marks every in-flight request to be discarded.
//   clk, rst                    : clock, synchronous active-high reset
//   imem_req_valid/ready/addr   : request channel (addr = fetch PC)
//   imem_resp_valid/data        : in-order response, no backpressure
//   redirect_valid/redirect_pc  : flush and restart fetch at redirect_pc
//   out_valid/ready/instr/pc    : instruction stream to decode
//   fq_count                    : fetch queue occupancy
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              ILEN     = DEF_ILEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int              PC_STEP  = DEF_PC_STEP,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           imem_req_valid,
    input  logic                           imem_req_ready,
    output logic [XLEN-1:0]                imem_req_addr,
    input  logic                           imem_resp_valid,
    input  logic [ILEN-1:0]                imem_resp_data,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ILEN-1:0]                out_instr,
    output logic [XLEN-1:0]                out_pc,
    output logic [occ_width(FQ_DEPTH)-1:0] fq_count
);

    localparam int CW = occ_width(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   pend;
    logic [CW-1:0]   kill;
    logic [CW:0]     credit_used;
    logic            pc_empty;
    logic            fq_empty;
    logic            req_fire;
    logic            resp_live;
    logic            resp_keep;
    logic            out_fire;
    logic [XLEN-1:0] resp_pc;

    // Occupancy of the address FIFO is exactly the number of accepted,
    // unanswered requests, so it serves as the pend counter.
    assign credit_used    = {1'b0, fq_count} + {1'b0, pend};
    assign imem_req_valid = !rst && !redirect_valid
                            && (credit_used < (CW+1)'(FQ_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding belongs to a request from before
    // reset and is ignored entirely.
    assign resp_live = imem_resp_valid && !pc_empty;
    assign resp_keep = resp_live && (kill == '0) && !redirect_valid;

    assign out_valid = !fq_empty && !redirect_valid;
    assign out_fire  = out_valid && out_ready;

    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .head_data (resp_pc),
        .count     (pend),
        .empty     (pc_empty)
    );

    fetch_queue #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data ({resp_pc, imem_resp_data}),
        .pop       (out_fire),
        .head_data ({out_pc, out_instr}),
        .count     (fq_count),
        .empty     (fq_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            kill     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            // Nothing issues in a redirect cycle, so everything still
            // outstanding after this edge's response is stale.
            kill     <= pend - CW'(resp_live);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            if (resp_live && (kill != '0)) kill <= kill - 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  fq_count;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fq_count        (fq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] rpc;
        logic [63:0] a0;
        logic [63:0] a1;
    } rvec_t;

    mreq_t       mq[$];
    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    int          cyc = 0;
    int          n_issued = 0;
    int          n_out = 0;
    bit          stream_chk = 1'b0;
    bit          mem_rst_clear = 1'b1;
    logic [63:0] exp_pc = 64'h0;
    logic [63:0] m_fetch_pc = 64'h0;

    function automatic logic [31:0] f_instr(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: sample handshakes before the edge, then advance the memory model.
    task automatic tick();
        bit          fire;
        bit          resp_was;
        bit          rst_was;
        logic [63:0] a;
        #1;
        fire     = imem_req_valid && imem_req_ready;
        a        = imem_req_addr;
        resp_was = imem_resp_valid;
        rst_was  = rst;
        if (fire) begin
            n_issued++;
            m_fetch_pc = a + 64'd4;
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (stream_chk) begin
                check("out_pc", out_pc, exp_pc);
                check("out_instr", {32'h0, out_instr}, {32'h0, f_instr(exp_pc)});
                exp_pc = exp_pc + 64'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (resp_was && mq.size() > 0) void'(mq.pop_front());
        if (rst_was && mem_rst_clear) mq.delete();
        if (fire) mq.push_back('{addr: a, due: cyc - 1 + lat});
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = f_instr(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    endtask

    task automatic wait_out(input string name, input int max);
        int k = 0;
        while (!out_valid && k < max) begin
            tick();
            k++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL %s timeout actual=out_valid 0 required=out_valid 1", name);
        end
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        check("redir_out_valid", {63'h0, out_valid}, 64'h0);
        check("redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        exp_pc         = {pc[63:2], 2'b00};
        m_fetch_pc     = {pc[63:2], 2'b00};
    endtask

    rvec_t vt[5];

    initial begin
        int n0;
        int i0;
        int k;
        logic [63:0] held;

        vt[0] = '{rpc: 64'h0000_0000_0000_1002, a0: 64'h0000_0000_0000_1000, a1: 64'h0000_0000_0000_1004};
        vt[1] = '{rpc: 64'hFFFF_FFFF_FFFF_FFFC, a0: 64'hFFFF_FFFF_FFFF_FFFC, a1: 64'h0000_0000_0000_0000};
        vt[2] = '{rpc: 64'hFFFF_FFFF_FFFF_FFFB, a0: 64'hFFFF_FFFF_FFFF_FFF8, a1: 64'hFFFF_FFFF_FFFF_FFFC};
        vt[3] = '{rpc: 64'h0000_0000_8000_0007, a0: 64'h0000_0000_8000_0004, a1: 64'h0000_0000_8000_0008};
        vt[4] = '{rpc: 64'h0000_0000_0000_0003, a0: 64'h0000_0000_0000_0000, a1: 64'h0000_0000_0000_0004};

        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        out_ready       = 1'b1;

        // Reset and first-fetch latency with 1-cycle memory
        tick();
        tick();
        check("rst_fq_count", {61'h0, fq_count}, 64'h0);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        rst = 1'b0;
        exp_pc = 64'h0;
        stream_chk = 1'b1;
        #1;
        check("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("first_req_addr", imem_req_addr, 64'h0);
        tick();
        check("lat_edge1_out_valid", {63'h0, out_valid}, 64'h0);
        tick();
        check("lat_edge2_out_valid", {63'h0, out_valid}, 64'h1);
        n0 = n_out;
        for (int i = 0; i < 10; i++) tick();
        check("steady_throughput", 64'(n_out - n0), 64'd10);

        // Decode stalled: credit stops issue at FQ_DEPTH
        out_ready = 1'b0;
        do_redirect(64'h0000_0000_0000_0100);
        i0 = n_issued;
        for (int i = 0; i < 10; i++) tick();
        check("stall_issued", 64'(n_issued - i0), 64'd4);
        check("stall_fq_count", {61'h0, fq_count}, 64'd4);
        check("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
        out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 12; i++) tick();
        check("release_stream", 64'(n_out - n0), 64'd12);

        // Redirect coinciding with a response and a pending output handshake
        k = 0;
        while (!(imem_resp_valid && fq_count != 3'd0) && k < 20) begin
            tick();
            k++;
        end
        check("redir_collide_setup", {63'h0, imem_resp_valid}, 64'h1);
        do_redirect(64'h0000_0000_0000_2000);
        check("redir_collide_fq_count", {61'h0, fq_count}, 64'h0);
        wait_out("redir_collide_out", 10);
        for (int i = 0; i < 4; i++) tick();

        // Memory request backpressure
        imem_req_ready = 1'b0;
        #1;
        held = imem_req_addr;
        check("hold_addr_model", held, m_fetch_pc);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_req_valid", {63'h0, imem_req_valid}, 64'h1);
            check("hold_req_addr", imem_req_addr, held);
        end
        imem_req_ready = 1'b1;
        i0 = n_issued;
        tick();
        check("hold_accept", 64'(n_issued - i0), 64'd1);
        check("hold_next_addr", imem_req_addr, held + 64'd4);
        for (int i = 0; i < 6; i++) tick();

        // Latency 3: redirect with three requests in flight
        lat = 3;
        k = 0;
        while (mq.size() != 3 && k < 30) begin
            tick();
            k++;
        end
        check("lat3_pend3", 64'(mq.size()), 64'd3);
        do_redirect(64'h0000_0000_0000_1002);
        #1;
        check("lat3_new_addr", imem_req_addr, 64'h0000_0000_0000_1000);
        wait_out("lat3_out", 20);
        check("lat3_first_pc", out_pc, 64'h0000_0000_0000_1000);
        for (int i = 0; i < 8; i++) tick();

        // Reset with two requests outstanding; late responses must be ignored
        imem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        imem_req_ready = 1'b1;
        i0 = n_issued;
        tick();
        tick();
        check("rst_mid_pend2", 64'(n_issued - i0), 64'd2);
        rst = 1'b1;
        mem_rst_clear = 1'b0;
        stream_chk = 1'b0;
        tick();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rst_late_fq_count", {61'h0, fq_count}, 64'h0);
        check("rst_late_out_valid", {63'h0, out_valid}, 64'h0);
        mem_rst_clear = 1'b1;
        imem_req_ready = 1'b1;
        exp_pc = 64'h0;
        m_fetch_pc = 64'h0;
        stream_chk = 1'b1;
        #1;
        check("rst_restart_addr", imem_req_addr, 64'h0);
        wait_out("rst_restart_out", 20);
        for (int i = 0; i < 6; i++) tick();

        // Table: redirect alignment and PC wrap, 1-cycle memory
        lat = 1;
        for (int t = 0; t < 5; t++) begin
            do_redirect(vt[t].rpc);
            #1;
            check("tbl_addr0", imem_req_addr, vt[t].a0);
            check("tbl_req_valid", {63'h0, imem_req_valid}, 64'h1);
            tick();
            check("tbl_addr1", imem_req_addr, vt[t].a1);
            wait_out("tbl_out", 10);
            for (int i = 0; i < 4; i++) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
